regfile_wport_arbiter: RTL

REGFILE_WPORT_ARBITER -- requirements
Module: regfile_wport_arbiter

---
 rtl/regfile_wport_arbiter_pkg.sv | 37 +++
 rtl/regfile_wport_arbiter_if.sv | 50 +++++
 rtl/wb_side_fifo.sv | 107 ++++++++++
 rtl/regfile_wport_arbiter.sv | 152 +++++++++++++++
 4 files changed

// File: rtl/regfile_wport_arbiter_pkg.sv
// regfile_wport_arbiter_pkg
// Shared core constants for the register-file write-port arbiter:
//   - default side-queue depth and starvation limit
//   - arbiter FSM state encoding
//   - write-back select codes (which source owns the write port this cycle)
//   - register-file write record and a source-register match helper
// No ports; imported by the interface, the side FIFO and the top.
package regfile_wport_arbiter_pkg;

  localparam int DEFAULT_DEPTH        = 2;
  localparam int DEFAULT_STARVE_LIMIT = 4;
  localparam int REG_ADDR_W           = 5;
  localparam int REG_DATA_W           = 32;

  typedef enum logic [0:0] {
    ARB_PIPE  = 1'b0,
    ARB_FORCE = 1'b1
  } arb_state_t;

  typedef enum logic [1:0] {
    WB_SEL_NONE = 2'd0,
    WB_SEL_PIPE = 2'd1,
    WB_SEL_SIDE = 2'd2
  } wb_sel_t;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] addr;
    logic [REG_DATA_W-1:0] data;
  } rf_write_t;

  // x0 is hardwired to zero, so a check against it never signals a hazard.
  function automatic logic addr_match(input logic [REG_ADDR_W-1:0] entry_addr,
                                      input logic [REG_ADDR_W-1:0] chk_addr);
    return (chk_addr != '0) && (entry_addr == chk_addr);
  endfunction

endpackage

// File: rtl/regfile_wport_arbiter_if.sv
// regfile_wport_arbiter_if
// Bundles every non-clock/reset signal of the register-file write-port
// arbiter.
//   pipe_valid/pipe_addr/pipe_data -> WB stage write request, pipe_ready <- stall
//   side_valid/side_addr/side_data -> long-latency unit write, side_ready <- accept
//   chk_addr1/chk_addr2            -> decode source registers, chk_hit <- pending
//   wr_en/wr_addr/wr_data          <- register-file write port
// master: the pipeline/testbench side; slave: the arbiter.
interface regfile_wport_arbiter_if;
  import regfile_wport_arbiter_pkg::*;

  logic                  pipe_valid;
  logic [REG_ADDR_W-1:0] pipe_addr;
  logic [REG_DATA_W-1:0] pipe_data;
  logic                  pipe_ready;

  logic                  side_valid;
  logic [REG_ADDR_W-1:0] side_addr;
  logic [REG_DATA_W-1:0] side_data;
  logic                  side_ready;

  logic [REG_ADDR_W-1:0] chk_addr1;
  logic [REG_ADDR_W-1:0] chk_addr2;
  logic                  chk_hit;

  logic                  wr_en;
  logic [REG_ADDR_W-1:0] wr_addr;
  logic [REG_DATA_W-1:0] wr_data;

  modport master (
    output pipe_valid, pipe_addr, pipe_data,
    input  pipe_ready,
    output side_valid, side_addr, side_data,
    input  side_ready,
    output chk_addr1, chk_addr2,
    input  chk_hit,
    input  wr_en, wr_addr, wr_data
  );

  modport slave (
    input  pipe_valid, pipe_addr, pipe_data,
    output pipe_ready,
    input  side_valid, side_addr, side_data,
    output side_ready,
    input  chk_addr1, chk_addr2,
    output chk_hit,
    output wr_en, wr_addr, wr_data
  );

endinterface

// File: rtl/wb_side_fifo.sv
// wb_side_fifo
// Side-write queue for the register-file write-port arbiter. Holds writes
// from long-latency units until the arbiter grants them the write port, in
// arrival order, and reports whether a decode-stage source register still
// has a pending (unwritten) queued write.
// Ports:
//   clk, rst               clock, asynchronous active-high reset
//   push, push_entry       enqueue request and record (ignored when full)
//   pop                    dequeue the head (ignored when empty)
//   head                   record at the head of the queue
//   empty, full            occupancy flags
//   chk_addr1, chk_addr2   source registers to look up
//   chk_hit                some valid entry targets a checked register
module wb_side_fifo
  import regfile_wport_arbiter_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  rf_write_t             push_entry,
  input  logic                  pop,
  output rf_write_t             head,
  output logic                  empty,
  output logic                  full,
  input  logic [REG_ADDR_W-1:0] chk_addr1,
  input  logic [REG_ADDR_W-1:0] chk_addr2,
  output logic                  chk_hit
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  rf_write_t        mem [DEPTH];
  logic [DEPTH-1:0] slot_valid;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CNT_W'(DEPTH));
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  // DEPTH is a power of two, so the pointers wrap by plain overflow.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Per-slot valid bits let the hazard lookup scan storage directly without
  // decoding the pointer window. A push and a pop never hit the same slot
  // in one cycle because push needs !full and pop needs !empty.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      slot_valid <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (do_pop && (rd_ptr == PTR_W'(i))) begin
          slot_valid[i] <= 1'b0;
        end
        if (do_push && (wr_ptr == PTR_W'(i))) begin
          slot_valid[i] <= 1'b1;
        end
      end
    end
  end

  // Payload storage needs no reset; slot_valid gates every use of it.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_entry;
    end
  end

  // The head being granted this cycle is still valid here, so it keeps
  // reporting a hit until the edge that launches its write.
  always_comb begin
    chk_hit = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (slot_valid[i] &&
          (addr_match(mem[i].addr, chk_addr1) || addr_match(mem[i].addr, chk_addr2))) begin
        chk_hit = 1'b1;
      end
    end
  end

endmodule

// File: rtl/regfile_wport_arbiter.sv
// regfile_wport_arbiter
// Shares the single register-file write port between the WB stage and a
// queue of writes from long-latency units. The WB stage normally wins; a
// queued write that has waited too long forces a one-cycle WB stall so it
// can drain. The write port outputs are registered (one cycle after grant).
// Ports:
//   clk        system clock, all state on posedge
//   rst        asynchronous active-high reset
//   bus        regfile_wport_arbiter_if.slave: WB request/stall, side
//              request/accept, decode hazard check, register-file write port
module regfile_wport_arbiter
  import regfile_wport_arbiter_pkg::*;
#(
  parameter int DEPTH        = DEFAULT_DEPTH,
  parameter int STARVE_LIMIT = DEFAULT_STARVE_LIMIT
) (
  input  logic                     clk,
  input  logic                     rst,
  regfile_wport_arbiter_if.slave   bus
);

  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);

  arb_state_t            state;
  arb_state_t            state_next;
  logic [CNT_W-1:0]      starve_cnt;
  logic [CNT_W-1:0]      starve_next;
  logic [CNT_W-1:0]      starve_inc;
  wb_sel_t               sel;
  logic                  pipe_ready_c;

  logic                  queue_push;
  logic                  queue_empty;
  logic                  queue_full;
  logic                  queue_hit;
  rf_write_t             side_entry;
  rf_write_t             head;

  logic                  wr_en_q;
  logic [REG_ADDR_W-1:0] wr_addr_q;
  logic [REG_DATA_W-1:0] wr_data_q;

  // Writes to x0 still complete the side handshake but are dropped here.
  assign side_entry.addr = bus.side_addr;
  assign side_entry.data = bus.side_data;
  assign queue_push      = bus.side_valid && !queue_full && (bus.side_addr != '0);

  wb_side_fifo #(
    .DEPTH (DEPTH)
  ) u_side_fifo (
    .clk        (clk),
    .rst        (rst),
    .push       (queue_push),
    .push_entry (side_entry),
    .pop        (sel == WB_SEL_SIDE),
    .head       (head),
    .empty      (queue_empty),
    .full       (queue_full),
    .chk_addr1  (bus.chk_addr1),
    .chk_addr2  (bus.chk_addr2),
    .chk_hit    (queue_hit)
  );

  // side_ready depends on occupancy alone, so a full queue refuses a new
  // entry even in a cycle where its head is being drained.
  assign bus.side_ready = !queue_full;
  assign bus.pipe_ready = pipe_ready_c;
  assign bus.chk_hit    = queue_hit;
  assign bus.wr_en      = wr_en_q;
  assign bus.wr_addr    = wr_addr_q;
  assign bus.wr_data    = wr_data_q;

  // State and starvation counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ARB_PIPE;
      starve_cnt <= '0;
    end else begin
      state      <= state_next;
      starve_cnt <= starve_next;
    end
  end

  // Grant selection, stall and starvation tracking. The counter measures
  // consecutive cycles the queue head has been passed over; once it reaches
  // STARVE_LIMIT-1 the next cycle belongs to the queue unconditionally.
  always_comb begin
    state_next   = state;
    starve_next  = starve_cnt;
    starve_inc   = starve_cnt + CNT_W'(1);
    sel          = WB_SEL_NONE;
    pipe_ready_c = 1'b1;
    unique case (state)
      ARB_PIPE: begin
        if (bus.pipe_valid) begin
          sel = WB_SEL_PIPE;
        end else if (!queue_empty) begin
          sel = WB_SEL_SIDE;
        end
        if (!queue_empty && (sel != WB_SEL_SIDE)) begin
          starve_next = starve_inc;
          if (starve_inc >= CNT_W'(STARVE_LIMIT - 1)) begin
            state_next = ARB_FORCE;
          end
        end else begin
          starve_next = '0;
        end
      end
      ARB_FORCE: begin
        pipe_ready_c = 1'b0;
        if (!queue_empty) begin
          sel = WB_SEL_SIDE;
        end
        starve_next = '0;
        state_next  = ARB_PIPE;
      end
      default: begin
        state_next  = ARB_PIPE;
        starve_next = '0;
      end
    endcase
  end

  // Registered write port. Address/data only move when a write is launched,
  // so an x0 pipe write or an idle cycle just drops wr_en.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else begin
      unique case (sel)
        WB_SEL_PIPE: begin
          wr_en_q <= (bus.pipe_addr != '0);
          if (bus.pipe_addr != '0) begin
            wr_addr_q <= bus.pipe_addr;
            wr_data_q <= bus.pipe_data;
          end
        end
        WB_SEL_SIDE: begin
          wr_en_q   <= 1'b1;
          wr_addr_q <= head.addr;
          wr_data_q <= head.data;
        end
        default: begin
          wr_en_q <= 1'b0;
        end
      endcase
    end
  end

endmodule
